// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: md_op encodings, FSM states, payloads.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU launch codes.
package mult_div_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Ops that start a multi-cycle computation
    function automatic logic is_launch(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_launch = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_launch = 1'b1;
`endif
            default: is_launch = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input md_op_e op);
        is_div = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational result datapath: latched op/operands (plus current HI/LO) -> next {hi,lo}.
// MDU_MADD_EN adds the accumulate/subtract forms of the multiply.
module mult_div_unit_arith
    import mult_div_unit_pkg::*;
(
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  hilo_t           cur,
    output hilo_t           res,
    output logic            hold
);

    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   div_b;
    logic [XLEN-1:0]   uq;
    logic [XLEN-1:0]   ur;
    logic [XLEN-1:0]   sq;
    logic [XLEN-1:0]   sr;
    logic [XLEN-1:0]   uq_u;
    logic [XLEN-1:0]   ur_u;

    always_comb begin
        prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
        prod_u = {XLEN'(0), a} * {XLEN'(0), b};

        // Signed divide via magnitudes; 0x80000000 / -1 wraps to 0x80000000 with no trap
        abs_a = a[XLEN-1] ? (XLEN'(0) - a) : a;
        abs_b = b[XLEN-1] ? (XLEN'(0) - b) : b;
        div_b = (b == XLEN'(0)) ? XLEN'(1) : b;
        if (abs_b == XLEN'(0)) abs_b = XLEN'(1);
        uq    = abs_a / abs_b;
        ur    = abs_a % abs_b;
        sq    = (a[XLEN-1] ^ b[XLEN-1]) ? (XLEN'(0) - uq) : uq;
        sr    = a[XLEN-1] ? (XLEN'(0) - ur) : ur;
        uq_u  = a / div_b;
        ur_u  = a % div_b;

        res  = cur;
        hold = is_div(op) && (b == XLEN'(0));
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = '{hi: sr, lo: sq};
            MD_DIVU:  res = '{hi: ur_u, lo: uq_u};
`ifdef MDU_MADD_EN
            MD_MADD:  res = cur + prod_s;
            MD_MADDU: res = cur + prod_u;
            MD_MSUB:  res = cur - prod_s;
            MD_MSUBU: res = cur - prod_u;
`endif
            default:  res = cur;
        endcase
        if (hold) res = cur;
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply/divide unit: launch FSM, busy counter and the HI/LO registers.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (multiply latency).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = mult_div_unit_pkg::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = mult_div_unit_pkg::DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [3:0]      md_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    md_op_e           op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    md_op_e           op_in;
    logic             launch_c;
    logic             commit_c;
    logic             mthi_c;
    logic             mtlo_c;
    hilo_t            res;
    logic             hold;

    assign op_in = md_op_e'(md_op);

    // Next-state, counter and strobe decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch_c   = 1'b0;
        commit_c   = 1'b0;
        mthi_c     = 1'b0;
        mtlo_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_launch(op_in)) begin
                    state_next = ST_RUN;
                    launch_c   = 1'b1;
                    cnt_next   = is_div(op_in) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end else if (!start) begin
                    mthi_c = (op_in == MD_MTHI);
                    mtlo_c = (op_in == MD_MTLO);
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(0)) begin
                    state_next = ST_IDLE;
                    commit_c   = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= CNT_W'(0);
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next == ST_RUN);
        end
    end

    // Operands are captured only at launch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= MD_NONE;
            a_q  <= XLEN'(0);
            b_q  <= XLEN'(0);
        end else if (launch_c) begin
            op_q <= op_in;
            a_q  <= src_a;
            b_q  <= src_b;
        end
    end

    mult_div_unit_arith u_arith (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .cur  ('{hi: hi, lo: lo}),
        .res  (res),
        .hold (hold)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= XLEN'(0);
            lo <= XLEN'(0);
        end else if (commit_c) begin
            if (!hold) begin
                hi <= res.hi;
                lo <= res.lo;
            end
        end else begin
            if (mthi_c) hi <= src_a;
            if (mtlo_c) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with a result scoreboard plus corner sequences.
// Define MDU_MADD_EN to exercise the accumulate ops.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    hilo_t exp_q[$];

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] init_hi;
        logic [31:0] init_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
        int          mid;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ih, input logic [31:0] il,
                                input logic [31:0] eh, input logic [31:0] el,
                                input int cyc, input int mid);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.init_hi = ih; v.init_lo = il;
        v.exp_hi = eh; v.exp_lo = el; v.cyc = cyc; v.mid = mid;
        return v;
    endfunction

    task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        start = 1'b0; md_op = 4'(MD_MTHI); src_a = h;
        @(negedge clk);
        md_op = 4'(MD_MTLO); src_a = l;
        @(negedge clk);
        md_op = 4'(MD_NONE);
    endtask

    // mid: 0 nothing, 1 second start during RUN, 2 MTLO during RUN
    task automatic run_vec(input vec_t v);
        hilo_t e;
        int    n;
        load_hilo(v.init_hi, v.init_lo);
        chk("preload_hi", hi, v.init_hi);
        chk("preload_lo", lo, v.init_lo);
        start = 1'b1; md_op = 4'(v.op); src_a = v.a; src_b = v.b;
        e.hi = v.exp_hi; e.lo = v.exp_lo;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; md_op = 4'(MD_NONE); src_a = $urandom; src_b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            if (n == 2 && v.mid == 1) begin
                start = 1'b1; md_op = 4'(MD_DIV); src_a = 32'd100; src_b = 32'd3;
            end else if (n == 2 && v.mid == 2) begin
                start = 1'b0; md_op = 4'(MD_MTLO); src_a = 32'hDEADBEEF;
            end else begin
                start = 1'b0; md_op = 4'(MD_NONE);
            end
            @(negedge clk);
        end
        start = 1'b0; md_op = 4'(MD_NONE);
        chk("busy_cycles", 32'(n), 32'(v.cyc));
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk("result_hi", hi, e.hi);
            chk("result_lo", lo, e.lo);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; md_op = 4'(MD_NONE); src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        md_op = 4'(MD_MTHI); src_a = 32'h12345678;
        @(negedge clk);
        md_op = 4'(MD_NONE);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_lo", lo, 32'd0);

        vecs[0]  = mk(MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0);
        vecs[1]  = mk(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5, 0);
        vecs[2]  = mk(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
        vecs[3]  = mk(MD_DIVU,  32'd7,        32'd0,        32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555, 32'h5555AAAA, 10, 0);
        vecs[4]  = mk(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h00000000, 32'h80000000, 10, 0);
        vecs[5]  = mk(MD_DIVU,  32'd100,      32'd7,        32'h0, 32'h0, 32'd2,        32'd14,       10, 0);
        vecs[6]  = mk(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'd1,        32'hFFFFFFFD, 10, 0);
        vecs[7]  = mk(MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 5, 0);
        vecs[8]  = mk(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h00000000, 32'h00000001, 5, 0);
        vecs[9]  = mk(MD_MULT,  32'd5,        32'd6,        32'h0, 32'h0, 32'h00000000, 32'd30,       5, 1);
        vecs[10] = mk(MD_DIV,   32'd7,        32'd0,        32'h13579BDF, 32'h2468ACE0, 32'h13579BDF, 32'h2468ACE0, 10, 2);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Non-launch op with start: no launch and no HI write
        start = 1'b1; md_op = 4'(MD_MTHI); src_a = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0; md_op = 4'(MD_NONE);
        chk("nonlaunch_busy", 32'(busy), 32'd0);
        chk("nonlaunch_hi", hi, 32'h13579BDF);

`ifdef MDU_MADD_EN
        run_vec(mk(MD_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5, 0));
        run_vec(mk(MD_MSUB,  32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0));
        run_vec(mk(MD_MADD,  32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, 32'h0, 32'h3, 5, 0));
`else
        load_hilo(32'h0, 32'hFFFFFFFF);
        start = 1'b1; md_op = 4'(MD_MADDU); src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0; md_op = 4'(MD_NONE);
        for (int k = 0; k < 6; k++) begin
            chk("madd_off_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        chk("madd_off_hi", hi, 32'h0);
        chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset asserted during busy cycle 3 aborts without a commit
        load_hilo(32'h11111111, 32'h22222222);
        start = 1'b1; md_op = 4'(MD_MULT); src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0; md_op = 4'(MD_NONE);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("postreset_busy", 32'(busy), 32'd0);
        chk("postreset_hi", hi, 32'd0);
        chk("postreset_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
